// File: rtl/wb_port_arbiter_pkg.sv
// Shared writeback definitions: arbiter FSM states, buffered MDU result entry
// and the default starvation limit.
package wb_port_arbiter_pkg;

  localparam int WB_DATA_W       = 32;
  localparam int WB_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_FORCE = 2'd2
  } arbState_t;

  // Data field is sized for the widest write port; narrower ports use the low bits.
  typedef struct packed {
    logic                 valid;
    logic [4:0]           rd;
    logic [WB_DATA_W-1:0] data;
  } wbEntry_t;

endpackage

// File: rtl/wb_port_arbiter_result_fifo.sv
// Circular buffer of pending MDU results with push, pop, count and
// per-entry invalidation of every entry whose rd matches a younger write.
module wb_result_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int W     = WB_DATA_W,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [4:0]                 i_pushRd,
  input  logic [W-1:0]               i_pushData,
  input  logic                       i_pop,
  input  logic                       i_invEn,
  input  logic [4:0]                 i_invRd,
  output logic                       o_headValid,
  output logic [4:0]                 o_headRd,
  output logic [W-1:0]               o_headData,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  wbEntry_t        r_mem [DEPTH];
  logic [PW-1:0]   r_rdPtr;
  logic [PW-1:0]   r_wrPtr;
  logic [CW-1:0]   r_count;

  logic            w_doPush;
  logic            w_doPop;

  // A push into a full buffer is legal only when the head leaves on the same edge.
  assign w_doPop  = i_pop && (r_count != '0);
  assign w_doPush = i_push && ((r_count < FULL) || w_doPop);

  assign o_headValid = (r_count != '0) && r_mem[r_rdPtr].valid;
  assign o_headRd    = r_mem[r_rdPtr].rd;
  assign o_headData  = W'(r_mem[r_rdPtr].data);
  assign o_count     = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (i_invEn) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (r_mem[i].rd == i_invRd) begin
            r_mem[i].valid <= 1'b0;
          end
        end
      end

      // The freshly written slot overrides any invalidation of its stale contents.
      if (w_doPush) begin
        r_mem[r_wrPtr].valid <= 1'b1;
        r_mem[r_wrPtr].rd    <= i_pushRd;
        r_mem[r_wrPtr].data  <= WB_DATA_W'(i_pushData);
        r_wrPtr <= (r_wrPtr == LAST_PTR) ? '0 : r_wrPtr + 1'b1;
      end

      if (w_doPop) begin
        r_rdPtr <= (r_rdPtr == LAST_PTR) ? '0 : r_rdPtr + 1'b1;
      end

      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the pipeline
// writeback stage and buffered multi-cycle MDU results, with starvation relief.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int W            = WB_DATA_W,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = WB_STARVE_LIMIT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pl_regwrite,
  input  logic [4:0]   pl_rd,
  input  logic [W-1:0] pl_data,
  input  logic         mdu_valid,
  input  logic [4:0]   mdu_rd,
  input  logic [W-1:0] mdu_data,
  output logic         mdu_ready,
  output logic         pl_stall,
  output logic         rf_we,
  output logic [4:0]   rf_addr,
  output logic [W-1:0] rf_wdata
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);
  localparam logic [AW-1:0] AGE_MAX = AW'(STARVE_LIMIT - 1);

  arbState_t       r_state;
  arbState_t       w_stateNext;
  logic [AW-1:0]   r_age;
  logic [AW-1:0]   w_ageNext;

  logic            r_rfWe;
  logic [4:0]      r_rfAddr;
  logic [W-1:0]    r_rfWdata;

  logic            w_headValid;
  logic [4:0]      w_headRd;
  logic [W-1:0]    w_headData;
  logic [CW-1:0]   w_count;
  logic [CW-1:0]   w_countNext;
  logic            w_nonEmpty;
  logic            w_plOwn;
  logic            w_pop;
  logic            w_push;
  logic            w_headWrite;

  assign pl_stall  = (r_state == ST_FORCE);
  assign mdu_ready = (w_count < FULL);

  assign w_nonEmpty = (w_count != '0);
  assign w_plOwn    = pl_regwrite && (pl_rd != 5'd0) && !pl_stall;

  // Cancelled heads drain immediately; live heads wait for a free port.
  assign w_pop       = w_nonEmpty && (!w_headValid || !w_plOwn);
  assign w_headWrite = w_pop && w_headValid;

  // x0 results and results already overwritten by the younger pipeline write are dropped.
  assign w_push = mdu_valid && mdu_ready && (mdu_rd != 5'd0) &&
                  !(w_plOwn && (pl_rd == mdu_rd));

  assign w_countNext = w_count + CW'(w_push) - CW'(w_pop);

  wb_result_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_pushRd    (mdu_rd),
    .i_pushData  (mdu_data),
    .i_pop       (w_pop),
    .i_invEn     (w_plOwn),
    .i_invRd     (pl_rd),
    .o_headValid (w_headValid),
    .o_headRd    (w_headRd),
    .o_headData  (w_headData),
    .o_count     (w_count)
  );

  always_comb begin
    w_stateNext = r_state;
    w_ageNext   = r_age;
    case (r_state)
      ST_IDLE: begin
        if (w_push) begin
          w_stateNext = ST_PEND;
          w_ageNext   = '0;
        end
      end
      ST_PEND: begin
        if (w_pop) begin
          w_ageNext   = '0;
          w_stateNext = (w_countNext == '0) ? ST_IDLE : ST_PEND;
        end else if (r_age == AGE_MAX) begin
          w_stateNext = ST_FORCE;
        end else begin
          w_ageNext = r_age + 1'b1;
        end
      end
      ST_FORCE: begin
        w_ageNext   = '0;
        w_stateNext = (w_countNext == '0) ? ST_IDLE : ST_PEND;
      end
      default: begin
        w_stateNext = ST_IDLE;
        w_ageNext   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_age   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_age   <= w_ageNext;
    end
  end

  // Address and data hold their last granted values while the port is idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rfWe    <= 1'b0;
      r_rfAddr  <= '0;
      r_rfWdata <= '0;
    end else begin
      r_rfWe <= w_plOwn || w_headWrite;
      if (w_plOwn) begin
        r_rfAddr  <= pl_rd;
        r_rfWdata <= pl_data;
      end else if (w_headWrite) begin
        r_rfAddr  <= w_headRd;
        r_rfWdata <= w_headData;
      end
    end
  end

  assign rf_we    = r_rfWe;
  assign rf_addr  = r_rfAddr;
  assign rf_wdata = r_rfWdata;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed vector bench for wb_port_arbiter: a per-cycle stimulus/expectation
// table plus hand-built sequences for back-pressure and reset during FORCE.
module tb_wb_port_arbiter;
  import wb_port_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        pl_regwrite;
  logic [4:0]  pl_rd;
  logic [31:0] pl_data;
  logic        mdu_valid;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        pl_stall;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic        plWe;
    logic [4:0]  plRd;
    logic [31:0] plData;
    logic        mduV;
    logic [4:0]  mduRd;
    logic [31:0] mduData;
    logic        expWe;
    logic [4:0]  expAddr;
    logic [31:0] expData;
    logic        expStall;
    logic        expReady;
    logic [1:0]  expState;
    logic        chkAddr;
  } vec_t;

  vec_t vecs[$];

  wb_port_arbiter #(
    .W            (32),
    .DEPTH        (2),
    .STARVE_LIMIT (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pl_regwrite (pl_regwrite),
    .pl_rd       (pl_rd),
    .pl_data     (pl_data),
    .mdu_valid   (mdu_valid),
    .mdu_rd      (mdu_rd),
    .mdu_data    (mdu_data),
    .mdu_ready   (mdu_ready),
    .pl_stall    (pl_stall),
    .rf_we       (rf_we),
    .rf_addr     (rf_addr),
    .rf_wdata    (rf_wdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(logic r, logic pw, logic [4:0] pr, logic [31:0] pd,
                              logic mv, logic [4:0] mr, logic [31:0] md,
                              logic ew, logic [4:0] ea, logic [31:0] ed,
                              logic es, logic ey, logic [1:0] est, logic ca);
    vec_t v;
    v.rst = r;  v.plWe = pw; v.plRd = pr; v.plData = pd;
    v.mduV = mv; v.mduRd = mr; v.mduData = md;
    v.expWe = ew; v.expAddr = ea; v.expData = ed;
    v.expStall = es; v.expReady = ey; v.expState = est; v.chkAddr = ca;
    return v;
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic applyStimulus(vec_t v);
    rst         = v.rst;
    pl_regwrite = v.plWe;
    pl_rd       = v.plRd;
    pl_data     = v.plData;
    mdu_valid   = v.mduV;
    mdu_rd      = v.mduRd;
    mdu_data    = v.mduData;
    @(posedge clk);
    #1;
  endtask

  task automatic runVec(string tag, vec_t v);
    applyStimulus(v);
    checkOutput($sformatf("%s rf_we", tag), 32'(rf_we), 32'(v.expWe));
    checkOutput($sformatf("%s pl_stall", tag), 32'(pl_stall), 32'(v.expStall));
    checkOutput($sformatf("%s mdu_ready", tag), 32'(mdu_ready), 32'(v.expReady));
    checkOutput($sformatf("%s state", tag), 32'(dut.r_state), 32'(v.expState));
    if (v.expWe || v.chkAddr) begin
      checkOutput($sformatf("%s rf_addr", tag), 32'(rf_addr), 32'(v.expAddr));
      checkOutput($sformatf("%s rf_wdata", tag), rf_wdata, v.expData);
    end
  endtask

  initial begin
    rst = 1'b1; pl_regwrite = 1'b0; pl_rd = '0; pl_data = '0;
    mdu_valid = 1'b0; mdu_rd = '0; mdu_data = '0;

    // reset, single push/drain, x0 on both sides, starvation, WAW, same-rd discard, push+pop
    vecs.push_back(mk(1,0, 0,32'h0,    0, 0,32'h0,        0, 0,32'h0,        0,1,ST_IDLE, 1));
    vecs.push_back(mk(1,0, 0,32'h0,    0, 0,32'h0,        0, 0,32'h0,        0,1,ST_IDLE, 1));
    vecs.push_back(mk(0,0, 0,32'h0,    1, 7,32'h12345678, 0, 0,32'h0,        0,1,ST_PEND, 0));
    vecs.push_back(mk(0,0, 0,32'h0,    0, 0,32'h0,        1, 7,32'h12345678, 0,1,ST_IDLE, 1));
    vecs.push_back(mk(0,0, 0,32'h0,    0, 0,32'h0,        0, 0,32'h0,        0,1,ST_IDLE, 0));
    vecs.push_back(mk(0,1, 0,32'hDEAD, 1, 0,32'hBEEF,     0, 0,32'h0,        0,1,ST_IDLE, 0));
    vecs.push_back(mk(0,1, 5,32'h55,   0, 0,32'h0,        1, 5,32'h55,       0,1,ST_IDLE, 1));
    vecs.push_back(mk(0,1, 5,32'h100,  1, 3,32'h3333,     1, 5,32'h100,      0,1,ST_PEND, 1));
    vecs.push_back(mk(0,1, 5,32'h101,  0, 0,32'h0,        1, 5,32'h101,      0,1,ST_PEND, 1));
    vecs.push_back(mk(0,1, 5,32'h102,  0, 0,32'h0,        1, 5,32'h102,      0,1,ST_PEND, 1));
    vecs.push_back(mk(0,1, 5,32'h103,  0, 0,32'h0,        1, 5,32'h103,      0,1,ST_PEND, 1));
    vecs.push_back(mk(0,1, 5,32'h104,  0, 0,32'h0,        1, 5,32'h104,      1,1,ST_FORCE,1));
    vecs.push_back(mk(0,1, 5,32'h105,  0, 0,32'h0,        1, 3,32'h3333,     0,1,ST_IDLE, 1));
    vecs.push_back(mk(0,1, 5,32'h200,  1, 9,32'h9999,     1, 5,32'h200,      0,1,ST_PEND, 1));
    vecs.push_back(mk(0,1, 9,32'hAA,   0, 0,32'h0,        1, 9,32'hAA,       0,1,ST_PEND, 1));
    vecs.push_back(mk(0,0, 0,32'h0,    0, 0,32'h0,        0, 0,32'h0,        0,1,ST_IDLE, 0));
    vecs.push_back(mk(0,0, 0,32'h0,    0, 0,32'h0,        0, 0,32'h0,        0,1,ST_IDLE, 0));
    vecs.push_back(mk(0,1,12,32'hC,    1,12,32'hD,        1,12,32'hC,        0,1,ST_IDLE, 1));
    vecs.push_back(mk(0,0, 0,32'h0,    0, 0,32'h0,        0, 0,32'h0,        0,1,ST_IDLE, 0));
    vecs.push_back(mk(0,0, 0,32'h0,    1, 4,32'h44,       0, 0,32'h0,        0,1,ST_PEND, 0));
    vecs.push_back(mk(0,0, 0,32'h0,    1, 6,32'h66,       1, 4,32'h44,       0,1,ST_PEND, 1));
    vecs.push_back(mk(0,0, 0,32'h0,    0, 0,32'h0,        1, 6,32'h66,       0,1,ST_IDLE, 1));

    foreach (vecs[i]) begin
      runVec($sformatf("vec%0d", i), vecs[i]);
    end

    // Back-pressure: third result held until the cycle after the forced pop.
    runVec("bp_a", mk(0,1,5,32'h1, 1,20,32'hA0, 1, 5,32'h1,  0,1,ST_PEND, 1));
    runVec("bp_b", mk(0,1,5,32'h2, 1,21,32'hA1, 1, 5,32'h2,  0,0,ST_PEND, 1));
    runVec("bp_c", mk(0,1,5,32'h3, 1,22,32'hA2, 1, 5,32'h3,  0,0,ST_PEND, 1));
    runVec("bp_d", mk(0,1,5,32'h4, 1,22,32'hA2, 1, 5,32'h4,  0,0,ST_PEND, 1));
    runVec("bp_e", mk(0,1,5,32'h5, 1,22,32'hA2, 1, 5,32'h5,  1,0,ST_FORCE,1));
    runVec("bp_f", mk(0,1,5,32'h6, 1,22,32'hA2, 1,20,32'hA0, 0,1,ST_PEND, 1));
    runVec("bp_g", mk(0,1,5,32'h7, 1,22,32'hA2, 1, 5,32'h7,  0,0,ST_PEND, 1));
    runVec("bp_h", mk(0,0,0,32'h0, 0, 0,32'h0,  1,21,32'hA1, 0,1,ST_PEND, 1));
    runVec("bp_i", mk(0,0,0,32'h0, 0, 0,32'h0,  1,22,32'hA2, 0,1,ST_IDLE, 1));

    // Reset while in FORCE with two entries buffered: nothing may drain afterwards.
    runVec("rf_a", mk(0,1,5,32'h1, 1,24,32'hB0, 1,5,32'h1, 0,1,ST_PEND, 1));
    runVec("rf_b", mk(0,1,5,32'h2, 1,25,32'hB1, 1,5,32'h2, 0,0,ST_PEND, 1));
    runVec("rf_c", mk(0,1,5,32'h3, 0, 0,32'h0,  1,5,32'h3, 0,0,ST_PEND, 1));
    runVec("rf_d", mk(0,1,5,32'h4, 0, 0,32'h0,  1,5,32'h4, 0,0,ST_PEND, 1));
    runVec("rf_e", mk(0,1,5,32'h5, 0, 0,32'h0,  1,5,32'h5, 1,0,ST_FORCE,1));
    runVec("rf_f", mk(1,0,0,32'h0, 0, 0,32'h0,  0,0,32'h0, 0,1,ST_IDLE, 1));
    for (int k = 0; k < 4; k++) begin
      runVec($sformatf("rf_post%0d", k),
             mk(0,0,0,32'h0, 0,0,32'h0, 0,0,32'h0, 0,1,ST_IDLE, 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter: W, default 32, data width of the register-file write port.
REQ-002 Parameter: DEPTH, default 2, number of entries in the MDU result buffer.
REQ-003 Parameter: STARVE_LIMIT, default 4, number of cycles a buffer head may wait before the pipeline is forced to yield.
REQ-004 Port: clk, input, 1, the single clock; all state updates on the rising edge.
REQ-005 Port: rst, input, 1, synchronous, active-high reset.
REQ-006 Port: pl_regwrite, input, 1, the pipeline writeback stage requests a write this cycle.
REQ-007 Port: pl_rd, input, 5, the pipeline destination register.
REQ-008 Port: pl_data, input, W, the pipeline writeback value (the ResultSrc mux output).
REQ-009 Port: mdu_valid, input, 1, the multi-cycle mul/div unit presents a result.
REQ-010 Port: mdu_rd, input, 5, the MDU destination register.
REQ-011 Port: mdu_data, input, W, the MDU result.
REQ-012 Port: mdu_ready, output, 1, high when the buffer can accept an MDU result (count < DEPTH).
REQ-013 Port: pl_stall, output, 1, requests that the pipeline hold writeback for one cycle.
REQ-014 Port: rf_we, output, 1, register-file write enable (registered).
REQ-015 Port: rf_addr, output, 5, register-file write address (registered).
REQ-016 Port: rf_wdata, output, W, register-file write data (registered).

Function
REQ-017 An MDU transfer SHALL occur when mdu_valid and mdu_ready are both high at a clock edge; the result is pushed into the FIFO tail.
REQ-018 The pipeline SHALL own the write port whenever pl_regwrite=1, pl_rd!=0 and pl_stall=0; the port drives pl_rd/pl_data on rf_* in the next cycle.
REQ-019 The buffer head SHALL be popped and written when the pipeline does not own the port (pl_regwrite=0, pl_rd=0, or pl_stall=1); rf_* shows the head in the next cycle.
REQ-020 Write latency SHALL be exactly 1 cycle from the sampled input or head to rf_*; rf_we=0 in every cycle with no grant.
REQ-021 Writes to x0 SHALL never assert rf_we; an MDU result with rd=0 is accepted and discarded without occupying the buffer.
REQ-022 WAW cancellation: a pipeline grant to rd=R SHALL invalidate every buffered entry with rd=R in the same edge; invalidated entries pop without asserting rf_we and without waiting for a free port.
REQ-023 An MDU result accepted in the same cycle as a pipeline grant to the same rd SHALL be discarded, since the pipeline instruction is younger.
REQ-024 Push and pop SHALL be allowed in the same cycle, including when count=DEPTH-1 or when count=DEPTH with a pop.
REQ-025 mdu_ready SHALL be derived only from the registered count, with no combinational path from mdu_valid.
REQ-026 FSM states:
  - IDLE: buffer empty.
  - PEND: buffer non-empty, opportunistic drain.
  - FORCE: pl_stall=1.
REQ-027 IDLE->PEND on a valid push; PEND->IDLE when the last valid entry pops and there is no push.
REQ-028 Age counter: cleared on entry to PEND and on every pop; increments in each PEND cycle the head is not popped.
REQ-029 PEND->FORCE when age reaches STARVE_LIMIT-1 without a pop.
REQ-030 FORCE SHALL last exactly one cycle: pipeline inputs are ignored, the head is popped, and the next state is PEND if entries remain, else IDLE.
REQ-031 pl_stall SHALL be a Moore output equal to (state==FORCE).

Reset
REQ-032 While rst=1 at an edge, the block SHALL clear: state=IDLE, count=0, age=0, rf_we=0, rf_addr=0, rf_wdata=0, pl_stall=0.
REQ-033 Reset mid-operation SHALL drop all buffered entries without writing them.
REQ-034 mdu_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-035 The FSM state enum, the buffer entry struct {valid, rd, data} and the default STARVE_LIMIT SHALL live in the shared pipeline package.
REQ-036 The buffer SHALL be a sub-module wb_result_fifo (push, pop, per-entry rd-match invalidate, count); the arbiter FSM and grant logic stay in wb_port_arbiter.

Verification
REQ-037 Scenario: MDU pushes rd=7, data=0x12345678 while pl_regwrite=0 -> the next cycle shows rf_we=1, rf_addr=7, rf_wdata=0x12345678, and state returns to IDLE.
REQ-038 Scenario: MDU pushes rd=3 and the pipeline writes rd=5 every cycle -> pl_stall=1 exactly 4 cycles after the push (STARVE_LIMIT=4), then rf_addr=3 in the following cycle.
REQ-039 Scenario: the buffer holds rd=9, then the pipeline writes rd=9, data=0xAA -> rf_addr=9, rf_wdata=0xAA, and the buffered entry is never written.
REQ-040 Scenario: two MDU pushes under continuous pipeline writes -> mdu_ready=0; a third mdu_valid is held and accepted in the cycle after the first pop.
REQ-041 Scenario: MDU rd=0 and pipeline rd=0 in the same cycle -> rf_we stays 0 and count stays 0.
REQ-042 Scenario: rst asserted with count=2 in FORCE -> the next cycle shows IDLE, rf_we=0, pl_stall=0, and no stale write appears afterwards.
